// File: rtl/controller_sample_logger_if.sv
// rtl/controller_sample_logger_if.sv - sample stream interface for the capture engine
// Purpose: carries the 32-bit valid/ready sample stream into controller_sample_logger.
// Signals:
//   in_valid  source -> logger  sample valid
//   in_ready  logger -> source  sample accepted when in_valid & in_ready at a rising edge
//   in_data   source -> logger  32-bit sample
// Modports: master = sample source, slave = logger.
interface controller_sample_logger_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/controller_sample_logger.sv
// rtl/controller_sample_logger.sv - streaming sample capture into a RAM ring buffer with block headers
// Purpose: accepts samples from in_if and writes them as a ring of 2**DEPTH_LOG2 words starting at
//   BASE_ADDR through the data RAM s2 port. After every BLOCK_WORDS samples (or on a partial flush when
//   enable drops) a header {seq[15:0], wr_index} is written to HEADER_ADDR.
// Ports:
//   clk, reset_n      clock (shared with RAM s2), synchronous active-low reset
//   enable            capture enable (level)
//   clear             synchronous pointer/sequence clear (pulse)
//   in_if             sample stream (slave side)
//   ram_address/ram_chipselect/ram_write/ram_byteenable/ram_writedata  RAM s2 write port, registered
//   wr_index          next ring slot to be written
//   block_done        one-cycle pulse coincident with each header write
module controller_sample_logger #(
  parameter int                    ADDR_WIDTH  = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 12'h800,
  parameter int                    DEPTH_LOG2  = 10,
  parameter int                    BLOCK_WORDS = 64,
  parameter logic [ADDR_WIDTH-1:0] HEADER_ADDR = 12'h7FF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   clear,
  controller_sample_logger_if.slave in_if,
  output logic [ADDR_WIDTH-1:0]  ram_address,
  output logic                   ram_chipselect,
  output logic                   ram_write,
  output logic [3:0]             ram_byteenable,
  output logic [31:0]            ram_writedata,
  output logic [DEPTH_LOG2-1:0]  wr_index,
  output logic                   block_done
);

  localparam int CNT_W = $clog2(BLOCK_WORDS + 1);

  typedef enum logic [1:0] {IDLE, RUN, HDR} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] blk_cnt, blk_cnt_next;
  logic [15:0]      seq;
  logic             ready;
  logic             accept;

  // Ready is dropped while clear is high so a sample is never handshaken on an edge that discards it.
  assign ready            = (state == RUN) && !clear;
  assign accept           = ready && in_if.in_valid;
  assign in_if.in_ready   = ready;
  assign ram_chipselect   = ram_write;
  assign ram_byteenable   = 4'hF;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      blk_cnt <= '0;
    end else begin
      state   <= state_next;
      blk_cnt <= blk_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    blk_cnt_next = blk_cnt;
    case (state)
      IDLE: begin
        if (enable) state_next = RUN;
      end
      RUN: begin
        if (accept) begin
          if (blk_cnt == CNT_W'(BLOCK_WORDS - 1)) begin
            state_next   = HDR;
            blk_cnt_next = '0;
          end else begin
            blk_cnt_next = blk_cnt + 1'b1;
          end
        end else if (!enable) begin
          // Partial flush: publish a header for the samples already written, then start a fresh block.
          state_next   = (blk_cnt != '0) ? HDR : IDLE;
          blk_cnt_next = '0;
        end
      end
      HDR: begin
        state_next = enable ? RUN : IDLE;
      end
      default: begin
        state_next   = IDLE;
        blk_cnt_next = '0;
      end
    endcase
    if (clear) begin
      state_next   = enable ? RUN : IDLE;
      blk_cnt_next = '0;
    end
  end

  // RAM write port and ring/sequence pointers. A data write and a header write can never collide:
  // ready is low in HDR, so the header always occupies its own cycle right after the last data write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ram_write     <= 1'b0;
      ram_address   <= '0;
      ram_writedata <= '0;
      block_done    <= 1'b0;
      wr_index      <= '0;
      seq           <= '0;
    end else begin
      ram_write  <= 1'b0;
      block_done <= 1'b0;
      if (clear) begin
        wr_index <= '0;
        seq      <= '0;
      end else if (accept) begin
        ram_write     <= 1'b1;
        ram_address   <= BASE_ADDR + ADDR_WIDTH'(wr_index);
        ram_writedata <= in_if.in_data;
        wr_index      <= wr_index + 1'b1;
      end else if (state == HDR) begin
        ram_write     <= 1'b1;
        block_done    <= 1'b1;
        ram_address   <= HEADER_ADDR;
        ram_writedata <= {seq, 16'(wr_index)};
        seq           <= seq + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_controller_sample_logger.sv
// tb/tb_controller_sample_logger.sv - scoreboard testbench for controller_sample_logger
module tb_controller_sample_logger;
  localparam int          RING   = 1024;
  localparam int          BW     = 64;
  localparam logic [11:0] BASE   = 12'h800;
  localparam logic [11:0] HEADER = 12'h7FF;
  localparam int P_IDLE = 0, P_RUN = 1, P_HDR = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [11:0] ram_address;
  logic        ram_chipselect;
  logic        ram_write;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic [9:0]  wr_index;
  logic        block_done;

  controller_sample_logger_if sif ();

  controller_sample_logger dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .clear          (clear),
    .in_if          (sif),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_byteenable (ram_byteenable),
    .ram_writedata  (ram_writedata),
    .wr_index       (wr_index),
    .block_done     (block_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [31:0] data;
    logic        hdr;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] last_hdr = '0;

  // Reference model state: ring pointer, header sequence, samples in current block, phase.
  int m_ptr = 0, m_seq = 0, m_cnt = 0, m_phase = P_IDLE;
  bit prev_rn = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [11:0] a, input logic [31:0] d, input logic h);
    exp_t e;
    e.cyc = cyc + 1; e.addr = a; e.data = d; e.hdr = h;
    exp_q.push_back(e);
  endtask

  // Applies the logger's rules to the inputs presented for the coming edge.
  task automatic model_step(input bit rn, input bit en, input bit clr, input bit v, input logic [31:0] d);
    if (!rn) begin
      m_ptr = 0; m_seq = 0; m_cnt = 0; m_phase = P_IDLE;
    end else if (clr) begin
      m_ptr = 0; m_seq = 0; m_cnt = 0; m_phase = en ? P_RUN : P_IDLE;
    end else if (m_phase == P_IDLE) begin
      if (en) m_phase = P_RUN;
    end else if (m_phase == P_RUN) begin
      if (v) begin
        push(BASE + 12'(m_ptr), d, 1'b0);
        m_ptr = (m_ptr + 1) % RING;
        m_cnt++;
        if (m_cnt == BW) begin m_cnt = 0; m_phase = P_HDR; end
      end else if (!en) begin
        m_phase = (m_cnt != 0) ? P_HDR : P_IDLE;
        m_cnt = 0;
      end
    end else begin
      push(HEADER, (m_seq << 16) | m_ptr, 1'b1);
      m_seq = (m_seq + 1) % 65536;
      m_phase = en ? P_RUN : P_IDLE;
    end
  endtask

  task automatic cycle(input bit rn, input bit en, input bit clr, input bit v, input logic [31:0] d);
    @(negedge clk);
    if (!prev_rn) begin
      check("rst_ram_write", 32'(ram_write), 32'd0);
      check("rst_ram_cs", 32'(ram_chipselect), 32'd0);
      check("rst_block_done", 32'(block_done), 32'd0);
      check("rst_ram_address", 32'(ram_address), 32'd0);
      check("rst_ram_writedata", ram_writedata, 32'd0);
    end
    reset_n = rn; enable = en; clear = clr; sif.in_valid = v; sif.in_data = d;
    #1;
    check("in_ready", 32'(sif.in_ready), 32'((m_phase == P_RUN) && !clr));
    check("wr_index", 32'(wr_index), 32'(m_ptr));
    model_step(rn, en, clr, v, d);
    prev_rn = rn;
  endtask

  // Monitor: every RAM write must match the oldest expectation, in the predicted cycle.
  always @(negedge clk) begin
    exp_t e;
    check("ram_cs_eq_write", 32'(ram_chipselect), 32'(ram_write));
    check("ram_byteenable", 32'(ram_byteenable), 32'hF);
    if (ram_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 32'(ram_address), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("write_cycle", 32'(cyc), 32'(e.cyc));
        check("write_addr", 32'(ram_address), 32'(e.addr));
        check("write_data", ram_writedata, e.data);
        check("block_done", 32'(block_done), 32'(e.hdr));
        if (ram_address == HEADER_ADDR_TB()) last_hdr = ram_writedata;
      end
    end else begin
      check("block_done_idle", 32'(block_done), 32'd0);
      if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("missing_write_addr", 32'hFFFF_FFFF, 32'(e.addr));
      end
    end
  end

  function automatic logic [11:0] HEADER_ADDR_TB();
    return HEADER;
  endfunction

  initial begin
    sif.in_valid = 1'b0;
    sif.in_data  = '0;

    // 1: reset then enable
    repeat (3) cycle(0, 0, 0, 0, 0);
    repeat (2) cycle(1, 1, 0, 0, 0);

    // 2: one full block of 64 samples
    last_hdr = '0;
    for (int i = 0; i < 64; i++) cycle(1, 1, 0, 1, 32'h1000 + i);
    repeat (3) cycle(1, 1, 0, 0, 0);
    check("t2_header", last_hdr, 32'h0000_0040);

    // 3: 1024 samples continuous plus one, from a fresh reset
    repeat (2) cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 16 * 65 + 1; i++) cycle(1, 1, 0, 1, $urandom);
    repeat (2) cycle(1, 1, 0, 0, 0);
    check("t3_last_header", last_hdr, 32'h000F_0000);

    // 4: partial block flushed by disable, then resume
    repeat (2) cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 1, $urandom);
    repeat (4) cycle(1, 0, 0, 0, 0);
    check("t4_partial_header", last_hdr, 32'h0000_000A);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 1, 32'hCAFE_0001);
    repeat (2) cycle(1, 1, 0, 0, 0);

    // 5: clear together with in_valid mid-block
    repeat (2) cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 1, $urandom);
    cycle(1, 1, 1, 1, 32'hDEAD_BEEF);
    for (int i = 0; i < 70; i++) cycle(1, 1, 0, 1, $urandom);
    repeat (3) cycle(1, 1, 0, 0, 0);

    // 6: reset during the header cycle
    repeat (2) cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 64; i++) cycle(1, 1, 0, 1, $urandom);
    cycle(0, 1, 0, 0, 0);
    repeat (2) cycle(1, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7), $urandom);
    end
    repeat (5) cycle(1, 0, 0, 0, 0);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
